// File: rtl/spi_adc_pkg.sv
// Shared types and elaboration helpers for the SPI ADC reader.
package spi_adc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      QUIET = 2'd2
   } spi_adc_state_e;

   localparam int SPI_ADC_MIN_CLK_DIV  = 2;
   localparam int SPI_ADC_MIN_QUIET    = 1;
   localparam int SPI_ADC_MIN_DATA_W   = 2;
   localparam int SPI_ADC_MAX_AVG_LOG2 = 8;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int spi_adc_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int spi_adc_bit_w(input int frame_bits);
      return spi_adc_cnt_w(frame_bits);
   endfunction

   function automatic int spi_adc_div_w(input int clk_div);
      return spi_adc_cnt_w(clk_div);
   endfunction

   function automatic bit spi_adc_params_ok(input int data_w, input int lead_bits,
                                            input int frame_bits, input int clk_div,
                                            input int quiet_cyc, input int avg_log2);
      return (data_w >= SPI_ADC_MIN_DATA_W) && (lead_bits >= 0) &&
             (lead_bits + data_w <= frame_bits) &&
             (clk_div >= SPI_ADC_MIN_CLK_DIV) && (clk_div % 2 == 0) &&
             (quiet_cyc >= SPI_ADC_MIN_QUIET) &&
             (avg_log2 >= 0) && (avg_log2 <= SPI_ADC_MAX_AVG_LOG2);
   endfunction

endpackage

// File: rtl/spi_adc_reader_if.sv
// Pin and sample-handshake bundle of the SPI ADC reader.
interface spi_adc_reader_if #(
   parameter int DATA_W = 12
) ();
   logic              start;
   logic              cont;
   logic              sdo;
   logic              cs_n;
   logic              sck;
   logic [DATA_W-1:0] sample;
   logic              sample_valid;
   logic              sample_ready;
   logic              overrun;
   logic              ovr_clr;
   logic              busy;

   modport master (
      input  start, cont, sdo, sample_ready, ovr_clr,
      output cs_n, sck, sample, sample_valid, overrun, busy
   );

   modport slave (
      output start, cont, sdo, sample_ready, ovr_clr,
      input  cs_n, sck, sample, sample_valid, overrun, busy
   );
endinterface

// File: rtl/spi_adc_sck_gen.sv
// SCK divider: registered sck plus combinational rise and frame-end strobes
// that coincide with the clk edge producing the sck 0->1 and the last 1->0.
module spi_adc_sck_gen
   import spi_adc_pkg::*;
#(
   parameter int CLK_DIV    = 2,
   parameter int FRAME_BITS = 16,
   localparam int BW        = spi_adc_bit_w(FRAME_BITS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   output logic          sck,
   output logic          rise,
   output logic          frame_end,
   output logic [BW-1:0] bit_idx
);

   localparam int DW = spi_adc_div_w(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [DW-1:0] RISE_AT  = DW'(CLK_DIV / 2 - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

   logic [DW-1:0] div, div_nxt;
   logic          wrap;

   assign wrap      = (div == DIV_LAST);
   assign div_nxt   = wrap ? '0 : div + 1'b1;
   assign rise      = en && (div == RISE_AT);
   assign frame_end = en && wrap && (bit_idx == BIT_LAST);

   // sck follows the count the divider is about to enter, so it stays registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div     <= '0;
         bit_idx <= '0;
         sck     <= 1'b0;
      end else if (!en) begin
         div     <= '0;
         bit_idx <= '0;
         sck     <= 1'b0;
      end else begin
         div <= div_nxt;
         sck <= (div_nxt >= DIV_HALF);
         if (wrap)
            bit_idx <= frame_end ? '0 : bit_idx + 1'b1;
      end
   end

endmodule

// File: rtl/spi_adc_reader.sv
// SPI ADC reader: frames conversions over CS/SCK/MISO, publishes on valid/ready.
// Build option SPI_ADC_AVG_EN averages 2^AVG_LOG2 frames per published sample.
module spi_adc_reader
   import spi_adc_pkg::*;
#(
   parameter int DATA_W     = 12,
   parameter int LEAD_BITS  = 2,
   parameter int FRAME_BITS = 16,
   parameter int CLK_DIV    = 2,
   parameter int QUIET_CYC  = 2,
   parameter int AVG_LOG2   = 2
) (
   input  logic             clk,
   input  logic             rst,
   spi_adc_reader_if.master bus
);

   localparam int BW  = spi_adc_bit_w(FRAME_BITS);
   localparam int BW1 = BW + 1;
   localparam int QW  = spi_adc_cnt_w(QUIET_CYC);
   localparam logic [BW:0]   WIN_LO = BW1'(LEAD_BITS);
   localparam logic [BW:0]   WIN_HI = BW1'(LEAD_BITS + DATA_W);
   localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYC - 1);
   localparam bit PARAMS_OK = spi_adc_params_ok(DATA_W, LEAD_BITS, FRAME_BITS,
                                                 CLK_DIV, QUIET_CYC, AVG_LOG2);

   generate
      if (!PARAMS_OK) begin : g_bad_params
         $error("spi_adc_reader: illegal parameter combination");
      end
   endgenerate

   spi_adc_state_e    state, state_nxt;
   logic [QW-1:0]     q_cnt;
   logic              rise, frame_end;
   logic [BW-1:0]     bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              in_win;
   logic              grp_open;
   logic              pub;
   logic [DATA_W-1:0] pub_word;

   spi_adc_sck_gen #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BITS (FRAME_BITS)
   ) u_sck (
      .clk       (clk),
      .rst       (rst),
      .en        (state == FRAME),
      .sck       (bus.sck),
      .rise      (rise),
      .frame_end (frame_end),
      .bit_idx   (bit_idx)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.start || bus.cont) state_nxt = FRAME;
         FRAME:   if (frame_end) state_nxt = QUIET;
         QUIET:   if (q_cnt == Q_LAST) state_nxt = (bus.cont || grp_open) ? FRAME : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cs_n and busy are decoded from the next state so they stay registered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         q_cnt    <= '0;
         bus.cs_n <= 1'b1;
         bus.busy <= 1'b0;
      end else begin
         state    <= state_nxt;
         q_cnt    <= (state == QUIET && state_nxt == QUIET) ? q_cnt + 1'b1 : '0;
         bus.cs_n <= (state_nxt != FRAME);
         bus.busy <= (state_nxt != IDLE);
      end
   end

   assign in_win = ({1'b0, bit_idx} >= WIN_LO) && ({1'b0, bit_idx} < WIN_HI);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         shreg <= '0;
      else if (rise && in_win)
         shreg <= {shreg[DATA_W-2:0], bus.sdo};
   end

`ifdef SPI_ADC_AVG_EN
   localparam int AW = DATA_W + AVG_LOG2;
   localparam int FW = spi_adc_cnt_w(1 << AVG_LOG2);
   localparam logic [FW-1:0] FRM_LAST = FW'((1 << AVG_LOG2) - 1);

   logic [AW-1:0] acc, acc_sum;
   logic [FW-1:0] frm_cnt;

   assign acc_sum  = acc + AW'(shreg);
   assign pub      = frame_end && (frm_cnt == FRM_LAST);
   // a partially collected group keeps the FSM framing even if cont drops
   assign grp_open = (frm_cnt != '0);
   assign pub_word = acc_sum[AW-1 -: DATA_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         frm_cnt <= '0;
      end else if (frame_end) begin
         if (pub) begin
            acc     <= '0;
            frm_cnt <= '0;
         end else begin
            acc     <= acc_sum;
            frm_cnt <= frm_cnt + 1'b1;
         end
      end
   end
`else
   assign pub      = frame_end;
   assign grp_open = 1'b0;
   assign pub_word = shreg;
`endif

   // a publish always wins over the handshake clearing valid
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.sample       <= '0;
         bus.sample_valid <= 1'b0;
         bus.overrun      <= 1'b0;
      end else begin
         if (pub) begin
            bus.sample       <= pub_word;
            bus.sample_valid <= 1'b1;
         end else if (bus.sample_valid && bus.sample_ready) begin
            bus.sample_valid <= 1'b0;
         end
         if (pub && bus.sample_valid && !bus.sample_ready)
            bus.overrun <= 1'b1;
         else if (bus.ovr_clr)
            bus.overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_adc_reader.sv
// Directed bench for spi_adc_reader at default parameters with a small ADC model
// that shifts {2'b00, value, 2'b00} out MSB first.
module tb_spi_adc_reader;

   logic clk;
   logic rst;
   int   n_chk = 0;
   int   n_err = 0;

   spi_adc_reader_if #(.DATA_W(12)) bus ();

   spi_adc_reader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ADC model: new word on cs_n fall, next bit after each sck rise
   int unsigned frames[$];
   logic [15:0] adc_word;
   int          adc_bit;
   bit          adc_on = 1'b0;

   always @(bus.cs_n or bus.sck) begin
      if (bus.cs_n !== 1'b0) begin
         adc_on  = 1'b0;
         bus.sdo = 1'b0;
      end else if (!adc_on) begin
         adc_word = 16'h0;
         if (frames.size() > 0)
            adc_word = {2'b00, 12'(frames.pop_front()), 2'b00};
         adc_bit = 15;
         adc_on  = 1'b1;
         bus.sdo = adc_word[adc_bit];
      end else if (bus.sck === 1'b1 && adc_bit > 0) begin
         adc_bit = adc_bit - 1;
         bus.sdo = adc_word[adc_bit];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int first_lo, last_lo, n_lo, n_pulse, np, p0, p1, n_hi;
   logic [11:0] s0, s1;
   logic prev_sck;

   initial begin
      rst              = 1'b0;
      bus.start        = 1'b0;
      bus.cont         = 1'b0;
      bus.sample_ready = 1'b0;
      bus.ovr_clr      = 1'b0;
      repeat (3) step();
      chk("rst_cs_n",    32'(bus.cs_n), 1);
      chk("rst_sck",     32'(bus.sck), 0);
      chk("rst_sample",  32'(bus.sample), 0);
      chk("rst_valid",   32'(bus.sample_valid), 0);
      chk("rst_overrun", 32'(bus.overrun), 0);
      chk("rst_busy",    32'(bus.busy), 0);
      rst = 1'b1;
      repeat (2) step();

`ifdef SPI_ADC_AVG_EN
      // four frames 100,101,102,104 -> one publish of 407>>2
      frames.push_back(100); frames.push_back(101);
      frames.push_back(102); frames.push_back(104);
      bus.sample_ready = 1'b1;
      bus.start = 1'b1;
      np = 0; p0 = 0; s0 = '0;
      for (int c = 1; c <= 170; c++) begin
         step();
         if (c == 1)  bus.start = 1'b0;
         if (c == 50) bus.start = 1'b1;
         if (c == 51) bus.start = 1'b0;
         if (bus.sample_valid) begin np++; p0 = c; s0 = bus.sample; end
      end
      chk("avg_npub",   32'(np), 1);
      chk("avg_sample", 32'(s0), 101);
      chk("avg_cycle",  32'(p0), 135);
      chk("avg_busy",   32'(bus.busy), 0);
      bus.sample_ready = 1'b0;
`else
      // single shot, start in cycle 0
      frames.push_back(12'hABC);
      bus.start = 1'b1;
      first_lo = -1; last_lo = -1; n_lo = 0; n_pulse = 0; prev_sck = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
         if (!bus.cs_n) begin
            n_lo++;
            if (first_lo < 0) first_lo = c;
            last_lo = c;
         end
         if (bus.sck && !prev_sck) n_pulse++;
         prev_sck = bus.sck;
         if (c == 32) chk("ss_valid_early", 32'(bus.sample_valid), 0);
         if (c == 33) begin
            chk("ss_sample", 32'(bus.sample), 32'hABC);
            chk("ss_valid",  32'(bus.sample_valid), 1);
         end
         if (c == 34) chk("ss_busy_quiet", 32'(bus.busy), 1);
         if (c == 35) chk("ss_busy_idle",  32'(bus.busy), 0);
      end
      chk("ss_cs_first", 32'(first_lo), 1);
      chk("ss_cs_last",  32'(last_lo), 32);
      chk("ss_cs_len",   32'(n_lo), 32);
      chk("ss_pulses",   32'(n_pulse), 16);
      bus.sample_ready = 1'b1;
      step();
      bus.sample_ready = 1'b0;
      chk("ss_consumed", 32'(bus.sample_valid), 0);

      // continuous, consumer always ready
      frames.push_back(12'h001); frames.push_back(12'hFFF);
      bus.sample_ready = 1'b1;
      bus.cont = 1'b1;
      np = 0; p0 = 0; p1 = 0; s0 = '0; s1 = '0; n_hi = 0;
      for (int c = 1; c <= 90; c++) begin
         step();
         if (c == 40) bus.cont = 1'b0;
         if (c >= 2 && c <= 66 && bus.cs_n) n_hi++;
         if (bus.sample_valid) begin
            if (np == 0) begin p0 = c; s0 = bus.sample; end
            else if (np == 1) begin p1 = c; s1 = bus.sample; end
            np++;
         end
      end
      chk("ct_npub",    32'(np), 2);
      chk("ct_s0",      32'(s0), 32'h001);
      chk("ct_s1",      32'(s1), 32'hFFF);
      chk("ct_spacing", 32'(p1 - p0), 34);
      chk("ct_cs_gap",  32'(n_hi), 2);
      chk("ct_overrun", 32'(bus.overrun), 0);
      chk("ct_busy",    32'(bus.busy), 0);
      bus.sample_ready = 1'b0;

      // overrun: two publishes without a consumer
      frames.push_back(12'h123); frames.push_back(12'h456);
      bus.cont = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         step();
         if (c == 40) bus.cont = 1'b0;
         if (c == 33) begin
            chk("ov_s0",    32'(bus.sample), 32'h123);
            chk("ov_clean", 32'(bus.overrun), 0);
         end
         if (c == 67) begin
            chk("ov_s1",    32'(bus.sample), 32'h456);
            chk("ov_set",   32'(bus.overrun), 1);
            chk("ov_valid", 32'(bus.sample_valid), 1);
         end
      end
      bus.ovr_clr = 1'b1;
      step();
      bus.ovr_clr = 1'b0;
      chk("ov_clr",       32'(bus.overrun), 0);
      chk("ov_clr_valid", 32'(bus.sample_valid), 1);
      bus.sample_ready = 1'b1;
      step();
      bus.sample_ready = 1'b0;
      chk("ov_consumed", 32'(bus.sample_valid), 0);

      // publish in the same cycle as a handshake
      frames.push_back(12'h0AA); frames.push_back(12'h555);
      bus.start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
      end
      chk("hs_first", 32'(bus.sample), 32'h0AA);
      bus.start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (c == 1)  bus.start = 1'b0;
         if (c == 32) bus.sample_ready = 1'b1;
         if (c == 33) begin
            chk("hs_valid",   32'(bus.sample_valid), 1);
            chk("hs_sample",  32'(bus.sample), 32'h555);
            chk("hs_overrun", 32'(bus.overrun), 0);
            bus.sample_ready = 1'b0;
         end
      end

      // reset during sck index 7 while a sample is still pending
      frames.push_back(12'h777);
      bus.start = 1'b1;
      for (int c = 1; c <= 16; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
      end
      chk("mr_sck_hi", 32'(bus.sck), 1);
      rst = 1'b0;
      #1;
      chk("mr_cs_n",  32'(bus.cs_n), 1);
      chk("mr_sck",   32'(bus.sck), 0);
      chk("mr_valid", 32'(bus.sample_valid), 0);
      chk("mr_busy",  32'(bus.busy), 0);
      repeat (2) step();
      rst = 1'b1;
      repeat (2) step();
      frames.push_back(12'h5A5);
      bus.start = 1'b1;
      for (int c = 1; c <= 34; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
         if (c == 33) begin
            chk("mr_sample", 32'(bus.sample), 32'h5A5);
            chk("mr_pub",    32'(bus.sample_valid), 1);
         end
      end
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
